// File: rtl/mul_sched.sv
// Two-requester round-robin scheduler in front of one iterative sign-magnitude multiplier.
// Accepted pairs are multiplied one magnitude bit per cycle; results come back with a requester tag.
module mul_sched #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_out,
  output logic              resp_ovf,
  output logic              busy
);

  localparam int MAG_W = DATA_W - 1;
  localparam int CNT_W = $clog2(MAG_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nx;
  logic                prio;
  logic                grant0, grant1;
  logic                accept, last_step, resp_fire;
  logic                sign, id;
  logic [2*MAG_W-1:0]  mcand, acc, acc_nx;
  logic [MAG_W-1:0]    mplier;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   a_sel, b_sel;

  // A zero magnitude is always reported as positive zero.
  function automatic logic [DATA_W-1:0] pack_result(input logic s, input logic [MAG_W-1:0] mag);
    return {s & (|mag), mag};
  endfunction

  always_comb begin
    grant0    = req0_valid && (!req1_valid || !prio);
    grant1    = req1_valid && (!req0_valid || prio);
    accept    = (state == IDLE) && rst && (grant0 || grant1);
    last_step = (state == RUN) && (cnt == CNT_W'(MAG_W - 1));
    resp_fire = (state == DONE) && resp_ready;
    acc_nx    = mplier[0] ? acc + mcand : acc;
    a_sel     = grant1 ? req1_a : req0_a;
    b_sel     = grant1 ? req1_b : req0_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = RUN;
      RUN:     if (last_step) state_nx = DONE;
      DONE:    if (resp_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = rst && (state == IDLE) && grant0;
    req1_ready = rst && (state == IDLE) && grant1;
    busy       = (state != IDLE);
  end

  // Operand capture, shift-and-add step, and response register on the final step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio       <= 1'b0;
      sign       <= 1'b0;
      id         <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_out   <= '0;
      resp_id    <= 1'b0;
      resp_ovf   <= 1'b0;
    end else if (accept) begin
      sign   <= a_sel[DATA_W-1] ^ b_sel[DATA_W-1];
      mcand  <= {{MAG_W{1'b0}}, a_sel[MAG_W-1:0]};
      mplier <= b_sel[MAG_W-1:0];
      acc    <= '0;
      cnt    <= '0;
      id     <= grant1;
    end else if (state == RUN) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (last_step) begin
        resp_valid <= 1'b1;
        resp_out   <= pack_result(sign, acc_nx[MAG_W-1:0]);
        resp_ovf   <= |acc_nx[2*MAG_W-1:MAG_W];
        resp_id    <= id;
      end
    end else if (resp_fire) begin
      resp_valid <= 1'b0;
      prio       <= ~resp_id;
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// Scoreboard bench for mul_sched: accepted requests queue their expected result,
// each response handshake pops and compares.
module tb_mul_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id, resp_ovf, busy;
  logic [31:0] resp_out;

  typedef struct packed {
    logic        id;
    logic [31:0] out;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] out_log[$];
  logic        id_log[$];
  logic        ovf_log[$];
  int          checks = 0;
  int          errors = 0;
  int          n_resp = 0;

  mul_sched #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_out(resp_out), .resp_ovf(resp_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic id);
    logic [61:0] p;
    exp_t e;
    p     = {31'b0, a[30:0]} * {31'b0, b[30:0]};
    e.id  = id;
    e.ovf = |p[61:31];
    e.out = {(a[31] ^ b[31]) && (p[30:0] != 31'd0), p[30:0]};
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (req0_valid && req0_ready) sb.push_back(model(req0_a, req0_b, 1'b0));
      if (req1_valid && req1_ready) sb.push_back(model(req1_a, req1_b, 1'b1));
      if (resp_valid && resp_ready) begin
        exp_t e;
        n_resp++;
        out_log.push_back(resp_out);
        id_log.push_back(resp_id);
        ovf_log.push_back(resp_ovf);
        if (sb.size() == 0) chk("unexpected_resp", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sb_out", resp_out, e.out);
          chk("sb_id", resp_id, e.id);
          chk("sb_ovf", resp_ovf, e.ovf);
        end
      end
    end
  end

  task automatic do_req(input int port, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    if (port == 0) begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    else           begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    #1;
    while (!(port == 0 ? req0_ready : req1_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("req_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, base;
    logic [31:0] hold_out;
    logic        hold_id, hold_ovf;

    rst = 1'b0; resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h0000_0009; req0_b = 32'h8000_0002;
    req1_valid = 1'b1; req1_a = 32'h8000_0007; req1_b = 32'h0000_0004;
    repeat (3) @(negedge clk);
    chk("rst_valid", resp_valid, 0);
    chk("rst_out", resp_out, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_ovf", resp_ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    @(posedge clk); #1 rst = 1'b1;

    fork
      begin do_req(0, 32'h0000_0009, 32'h8000_0002); do_req(0, 32'h0000_0009, 32'h8000_0002); end
      begin do_req(1, 32'h8000_0007, 32'h0000_0004); do_req(1, 32'h8000_0007, 32'h0000_0004); end
    join
    drain();
    chk("arb_count", n_resp, 4);
    if (n_resp >= 4) begin
      chk("arb_id0", id_log[0], 0);
      chk("arb_id1", id_log[1], 1);
      chk("arb_id2", id_log[2], 0);
      chk("arb_id3", id_log[3], 1);
      chk("arb_out0", out_log[0], 32'h8000_0012);
      chk("arb_out1", out_log[1], 32'h8000_001C);
    end

    do_req(0, 32'h0000_0005, 32'h8000_0003);
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!resp_valid && lat < 100);
    chk("latency", lat, 31);
    chk("single_out", resp_out, 32'h8000_000F);
    chk("single_id", resp_id, 0);
    chk("single_ovf", resp_ovf, 0);
    drain();

    do_req(0, 32'h8000_0004, 32'h8000_0003); drain();
    chk("negneg_out", out_log[$], 32'h0000_000C);
    do_req(1, 32'h8000_0005, 32'h0000_0000); drain();
    chk("poszero_out", out_log[$], 32'h0000_0000);
    chk("poszero_id", id_log[$], 1);
    do_req(1, 32'h0003_5AAB, 32'h0000_0001); drain();
    chk("ident_out", out_log[$], 32'h0003_5AAB);
    do_req(0, 32'h4000_0000, 32'h0000_0002); drain();
    chk("ovf_out", out_log[$], 32'h0000_0000);
    chk("ovf_flag", ovf_log[$], 1);
    do_req(1, 32'h7FFF_FFFF, 32'h8000_0001); drain();
    chk("max_out", out_log[$], 32'hFFFF_FFFF);
    chk("max_ovf", ovf_log[$], 0);

    for (int i = 0; i < 6; i++) begin
      do_req(i % 2, $urandom, $urandom & ((i < 3) ? 32'h8000_FFFF : 32'hFFFF_FFFF));
      drain();
    end

    resp_ready = 1'b0;
    do_req(0, 32'h0000_0011, 32'h8000_0011);
    req1_a = 32'h0000_0003; req1_b = 32'h0000_0006; req1_valid = 1'b1;
    n = 0;
    while (!resp_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_valid_seen", resp_valid, 1);
    chk("bp_out", resp_out, 32'h8000_0121);
    hold_out = resp_out; hold_id = resp_id; hold_ovf = resp_ovf;
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold_valid", resp_valid, 1);
      chk("bp_hold_out", resp_out, hold_out);
      chk("bp_hold_id", resp_id, hold_id);
      chk("bp_hold_ovf", resp_ovf, hold_ovf);
      chk("bp_rdy0", req0_ready, 0);
      chk("bp_rdy1", req1_ready, 0);
      chk("bp_busy", busy, 1);
    end
    base = n_resp;
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_one_hs", n_resp, base + 1);
    chk("bp_next_acc", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    drain();
    chk("bp_after_out", out_log[$], 32'h0000_0012);

    do_req(0, 32'h0001_2345, 32'h0000_0777);
    repeat (15) @(posedge clk);
    #2;
    chk("ar_pre_busy", busy, 1);
    req1_valid = 1'b1;
    rst = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_valid", resp_valid, 0);
    chk("ar_rdy1", req1_ready, 0);
    sb.delete();
    req1_valid = 1'b0;
    base = n_resp;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("ar_no_stale", n_resp, base);
    do_req(1, 32'h8000_0006, 32'h0000_0007); drain();
    chk("ar_new_count", n_resp, base + 1);
    chk("ar_new_out", out_log[$], 32'h8000_002A);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_sched.md
# mul_sched

Two-requester scheduler and sequencer for the shared 32-bit sign-magnitude multiplier resource. Arbitrates round-robin between two valid/ready request ports and runs the accepted operand pair through an iterative shift-and-add magnitude engine, one bit per cycle. Returns one tagged result per request on a valid/ready response port. Sits between the chip's operand sources and the result sink, replacing direct per-source multiplier instances.

## Interface
- DATA_W, 32, operand/result width; bit DATA_W-1 is sign, bits DATA_W-2:0 are magnitude (MAG_W = DATA_W-1)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 pair accepted this cycle when valid also high
- req0_a, req0_b  in  DATA_W  requester 0 operands, sign-magnitude
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  sink accepts result
- resp_id  out  1  requester that issued the result (0/1)
- resp_out  out  DATA_W  product, sign-magnitude
- resp_ovf  out  1  magnitude product did not fit in MAG_W bits
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: grant = requester whose valid is high; if both are high, grant the one at priority pointer `prio`. `reqN_ready = (state==IDLE) && grantN`. On handshake:
  - latch sign = a[MSB]^b[MSB], mcand = a magnitude (zero-extended to 2*MAG_W), mplier = b magnitude, acc = 0, cnt = 0, id = grant.
  - go to RUN.
- RUN, each cycle:
  - if mplier[0], acc += mcand;
  - mcand <<= 1; mplier >>= 1; cnt += 1;
  - after the MAG_W-th step (cnt == MAG_W-1 at the edge), go to DONE.
- DONE entry registers the response:
  - resp_out magnitude = acc[MAG_W-1:0];
  - resp_ovf = |acc[2*MAG_W-1:MAG_W];
  - resp_out sign = sign, forced to 0 when the truncated magnitude is 0, so no negative zero;
  - resp_id = id.
- DONE: hold resp_valid and all resp_* stable until resp_ready. On handshake: resp_valid = 0; `prio` = the requester that was not served; go to IDLE.
- Requests are never accepted outside IDLE. Requesters hold valid and operands until ready.
- The result sink sees one result per accepted request, in acceptance order.

## Timing
- Reset (rst low, asynchronous): state IDLE, prio = 0, resp_valid 0, resp_out 0, resp_id 0, resp_ovf 0, busy 0, internal acc/cnt 0. Both req ready outputs are 0 while rst is low.
- Reset mid-operation: the in-flight operation is discarded and no response is issued. The first accept is possible in the first cycle after rst deasserts.
- Latency: accept at edge E0. RUN steps happen at E1..E31 (MAG_W=31). resp_valid is high after E31, which is 31 cycles after accept.
- Throughput: the response handshake at edge Ed returns the FSM to IDLE. The next accept is possible at Ed+1. The minimum request-to-request period is 33 cycles with resp_ready tied high.
- reqN_ready depends combinationally on req valids and state. resp_* are registered outputs only.
- Simultaneous valids after reset: requester 0 wins. Afterwards, grants strictly alternate while both stay valid.
- A lone valid requester is granted regardless of `prio`.

## Test plan
- Single op: req0 with 0x00000005 × 0x80000003 → after 31 cycles resp_valid, resp_out=0x8000000F, resp_id=0, resp_ovf=0. Repeat with 0x80000004 × 0x80000003 → 0x0000000C.
- Zero/negative: req1 with 0x80000005 × 0x00000000 → resp_out=0x00000000 (positive zero), resp_id=1. Then 0x0003_5AAB × 0x00000001 → 0x00035AAB.
- Overflow: 0x40000000 × 0x00000002 → magnitude truncates to 0, so resp_out=0x00000000 with resp_ovf=1. 0x7FFFFFFF × 0x80000001 → resp_out=0xFFFFFFFF, resp_ovf=0.
- Arbitration: both valid continuously from reset with distinct operands (9×-2, -7×4) → results in order id 0 (0x80000012), id 1 (0x8000001C), id 0, id 1. No result is lost or duplicated.
- Backpressure: hold resp_ready low for 10 cycles in DONE → resp_* stable, both req ready outputs 0, busy 1. Raise resp_ready → one handshake, and the next accept occurs the following cycle.
- Async reset: assert rst low at RUN step 15 with no clock edge → resp_valid and busy drop immediately. After release, no stale response appears, and a new request completes normally.
